// File: rtl/count_enable_ctrl_pkg.sv
// Shared definitions for the run-control stage that feeds the digit counter's enable.
// Holds the run/pause state encoding and the default timing constants.
package count_enable_ctrl_pkg;

    typedef enum logic {
        ST_STOPPED = 1'b0,
        ST_RUNNING = 1'b1
    } run_state_e;

    localparam int DEFAULT_DIV        = 50000;
    localparam int DEFAULT_DEB_CYCLES = 1000;

endpackage

// File: rtl/button_debounce.sv
// Raw push-button conditioner: 2-flop synchroniser, run-length debounce counter
// and a one-cycle press pulse issued alongside the debounced 0->1 transition.
module button_debounce
    import count_enable_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES = DEFAULT_DEB_CYCLES,
    parameter int DEB_WIDTH  = 10
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    logic [1:0]           sync_q;
    logic                 sample;
    logic                 level_q, level_d;
    logic                 press_q, press_d;
    logic [DEB_WIDTH-1:0] cnt_q, cnt_d;

    assign sample = sync_q[1];

    // A new level is accepted only after DEB_CYCLES consecutive differing samples.
    always_comb begin
        level_d = level_q;
        press_d = 1'b0;
        cnt_d   = '0;
        if (sample != level_q) begin
            if (cnt_q == DEB_WIDTH'(DEB_CYCLES - 1)) begin
                level_d = sample;
                press_d = sample;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= 2'b00;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[0], btn_raw};
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/count_enable_ctrl.sv
// Run/pause and single-step control producing the downstream counter's enable pulse.
// While running, a prescaler emits one enable every DIV cycles; pausing keeps its phase.
module count_enable_ctrl
    import count_enable_ctrl_pkg::*;
#(
    parameter int DIV        = DEFAULT_DIV,
    parameter int DIV_WIDTH  = 16,
    parameter int DEB_CYCLES = DEFAULT_DEB_CYCLES,
    parameter int DEB_WIDTH  = 10
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_run,
    input  logic btn_step,
    output logic enable,
    output logic running
);

    logic run_evt, step_evt;
    logic unused_run_level, unused_step_level;

    run_state_e           state_q, state_d;
    logic [DIV_WIDTH-1:0] pre_q, pre_d;
    logic                 pre_at_top;
    logic                 enable_q, enable_d;
    logic                 running_q;

    button_debounce #(
        .DEB_CYCLES(DEB_CYCLES),
        .DEB_WIDTH (DEB_WIDTH)
    ) u_deb_run (
        .clk    (clk),
        .reset_n(reset_n),
        .btn_raw(btn_run),
        .level  (unused_run_level),
        .press  (run_evt)
    );

    button_debounce #(
        .DEB_CYCLES(DEB_CYCLES),
        .DEB_WIDTH (DEB_WIDTH)
    ) u_deb_step (
        .clk    (clk),
        .reset_n(reset_n),
        .btn_raw(btn_step),
        .level  (unused_step_level),
        .press  (step_evt)
    );

    assign pre_at_top = (pre_q == DIV_WIDTH'(DIV - 1));

    // A run press always wins over a simultaneous step press.
    always_comb begin
        state_d  = state_q;
        pre_d    = pre_q;
        enable_d = 1'b0;
        if (run_evt) begin
            state_d = (state_q == ST_RUNNING) ? ST_STOPPED : ST_RUNNING;
        end
        if (state_q == ST_RUNNING) begin
            pre_d    = pre_at_top ? '0 : pre_q + 1'b1;
            enable_d = pre_at_top;
        end else begin
            enable_d = step_evt && !run_evt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_STOPPED;
            pre_q     <= '0;
            enable_q  <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            enable_q  <= enable_d;
            running_q <= (state_d == ST_RUNNING);
        end
    end

    assign enable  = enable_q;
    assign running = running_q;

endmodule
